// File: rtl/dma_sram_ctrl.sv
// dma_sram_ctrl: streams len words between valid/ready ports and a 3072x32 SRAM; `DMA_SRAM_CTRL_BOUND_EN adds a base+len range check
module dma_sram_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3072
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_DI,
    input  logic [DATA_W-1:0] sram_DO,
    output logic              sram_CS,
    output logic              sram_WEB,
    output logic              sram_OE
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   remain_q, to_issue_q;
    logic              inflight_q, err_q;
    logic [1:0]        count_q, count_d, wr_idx;
    logic [DATA_W-1:0] fifo_q [3];
    logic              req_bad, wr_hs, issue, pop;

`ifdef DMA_SRAM_CTRL_BOUND_EN
    assign req_bad = (len == '0) || ({1'b0, len} > DEPTH_X) ||
                     (({2'b0, base_addr} + {1'b0, len}) > DEPTH_X);
`else
    assign req_bad = (len == '0) || ({1'b0, len} > DEPTH_X);
`endif

    assign cur_addr_d = (cur_addr_q == LAST_A) ? '0 : cur_addr_q + 1'b1;
    assign wr_hs      = (state_q == WRITE) && in_valid;
    // Occupancy uses only registered state, so out_ready never reaches sram_CS.
    assign issue      = (state_q == READ) && (to_issue_q != '0) &&
                        (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd3);
    assign pop        = out_valid && out_ready;
    assign count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign wr_idx     = count_q - {1'b0, pop};

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign in_ready  = (state_q == WRITE);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_q[0];
    assign sram_CS   = wr_hs || issue;
    assign sram_WEB  = !wr_hs;
    assign sram_OE   = (state_q == READ);
    assign sram_A    = (state_q == WRITE || state_q == READ) ? cur_addr_q : '0;
    assign sram_DI   = (state_q == WRITE) ? in_data : '0;

    // Transfer FSM: request check, address walk, issue and completion counting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            to_issue_q <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            inflight_q <= issue;
            case (state_q)
                IDLE: if (start) begin
                    if (req_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        state_q    <= mode ? READ : WRITE;
                        cur_addr_q <= base_addr;
                        remain_q   <= len;
                        to_issue_q <= len;
                    end
                end
                WRITE: if (wr_hs) begin
                    cur_addr_q <= cur_addr_d;
                    remain_q   <= remain_q - 1'b1;
                    if (remain_q == ONE) state_q <= DONE;
                end
                READ: begin
                    if (issue) begin
                        cur_addr_q <= cur_addr_d;
                        to_issue_q <= to_issue_q - 1'b1;
                    end
                    if (pop) begin
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == ONE) state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // 3-entry shift FIFO: head at index 0, SRAM word lands one cycle after its issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            fifo_q  <= '{default: '0};
        end else begin
            count_q <= count_d;
            if (pop) begin
                fifo_q[0] <= fifo_q[1];
                fifo_q[1] <= fifo_q[2];
            end
            if (inflight_q) fifo_q[wr_idx] <= sram_DO;
        end
    end
endmodule

// File: doc/dma_sram_ctrl.md
# dma_sram_ctrl

Initiator-side controller for the 3072×32 DMA SRAM macro. Moves a block of `len` consecutive words between a valid/ready stream and the SRAM. Write mode streams words in; read mode streams words out. The SRAM's 1-cycle registered read latency and its OE-gated output are absorbed by a 3-entry output FIFO. It sits between the DMA engine datapath and the SRAM macro pins (A/DI/DO/WEB/CS/OE).

## Interface
- `ADDR_W`, 12: SRAM word-address width.
- `DATA_W`, 32: word width.
- `DEPTH`, 3072: number of SRAM words.

Ports (`ADDR_W` = 12, `DATA_W` = 32 in the widths below):
- `clk` in 1: single clock, also drives the SRAM CK.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: 1-cycle request; ignored unless idle.
- `mode` in 1: 0 = write (stream→SRAM), 1 = read (SRAM→stream); sampled with `start`.
- `base_addr` in 12: first word address; sampled with `start`.
- `len` in 13: word count, legal range 1..3072; sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: 1-cycle pulse at transfer end.
- `err` out 1: 1-cycle pulse when a request is rejected.
- `in_valid` in 1, `in_data` in 32, `in_ready` out 1: write-data stream.
- `out_valid` out 1, `out_data` out 32, `out_ready` in 1: read-data stream.
- `sram_A` out 12, `sram_DI` out 32, `sram_DO` in 32, `sram_CS` out 1, `sram_WEB` out 1, `sram_OE` out 1: connect to the SRAM macro.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - `start` with a legal request → WRITE or READ according to `mode`. Load `cur_addr`=`base_addr`, `remain`=`len`.
  - `start` with an illegal request (`len`=0, or, with bounds check, `base_addr`+`len`>`DEPTH`) → `err`=1 next cycle, stay IDLE, no SRAM access.
- WRITE (all combinational from state):
  - `in_ready`=1.
  - `sram_CS`=`in_valid`, `sram_WEB`=0, `sram_A`=`cur_addr`, `sram_DI`=`in_data`.
  - Each handshake writes one word, increments `cur_addr`, decrements `remain`.
  - `remain` reaching 0 → DONE.
- READ, issue side:
  - A read is issued when `issued`<`len` and `fifo_count`+`inflight`<3.
  - Issue means `sram_CS`=1, `sram_WEB`=1, `sram_A`=`cur_addr`, then increment `cur_addr`.
  - `inflight` is set in the cycle after an issue. In that cycle `sram_DO` is valid and is pushed into the FIFO.
- READ, output side:
  - `sram_OE`=1 for the whole READ state.
  - `out_valid`=FIFO non-empty; `out_data`=FIFO head.
  - A pop on `out_valid`&&`out_ready` decrements `remain`.
  - `remain` reaching 0 → DONE.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE.
- `busy`=1 in WRITE, READ and DONE.
- `start` while `busy`: ignored, no `err`.
- `cur_addr` arithmetic is modulo `DEPTH`: 3071+1 → 0, not 3072.
- Async reset mid-transfer: abort immediately. FIFO, counters and FSM are cleared. SRAM contents are not restored.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `err`=0.
  - `in_ready`=0, `out_valid`=0, `out_data`=0.
  - `sram_CS`=0, `sram_WEB`=1, `sram_OE`=0, `sram_A`=0, `sram_DI`=0.
  - State IDLE, FIFO empty.
- Outside an active access: `sram_CS`=0, `sram_WEB`=1. `sram_OE`=0 outside READ.
- Write: `start` in cycle 0 → `in_ready`=1 from cycle 1. With `in_valid` held, one word per cycle. The last write happens in cycle `len`, `done` is in cycle `len`+1.
- Read: `start` in cycle 0 → first issue in cycle 1, `sram_DO` valid in cycle 2, `out_valid` from cycle 3.
- Read with `out_ready` held high: 1 word/cycle. The last pop is in cycle `len`+2, `done` is in cycle `len`+3.
- Read backpressure: at most 3 words are outstanding (buffered plus in flight). No word is dropped and none is duplicated.
- No combinational path from `out_ready` to `sram_CS`.

## Configuration
- `DMA_SRAM_CTRL_BOUND_EN` defined: a request with `base_addr`+`len`>`DEPTH` is rejected with `err`.
- Not defined: no range check. Addresses wrap modulo `DEPTH`. Only `len`=0 or `len`>3072 raises `err`.

## Test plan
- Write `base_addr`=0x010, `len`=4, data 0xA0..0xA3, `in_valid` held → four CS/WEB=0 cycles at 0x010..0x013, `done` in cycle 5, SRAM words match.
- Read back the same block with `out_ready`=1 → `out_data` 0xA0..0xA3 in cycles 3..6, `done` in cycle 7, `sram_OE`=1 throughout READ.
- Read `len`=8 with `out_ready` toggling 1,0,0,1… → in-order output with no loss. `fifo_count`+`inflight` never exceeds 3, `sram_CS` stalls while that sum is 3.
- `base_addr`=3070, `len`=4:
  - with `DMA_SRAM_CTRL_BOUND_EN` → `err` pulse, no `sram_CS`;
  - without it → addresses 3070, 3071, 0, 1.
- `len`=0 → `err`. `start` during an active transfer → ignored. `rstn` low mid-read → all outputs at reset values immediately; the next legal `start` works normally.
